// File: rtl/counter_checker_pkg.sv
// Shared types and the next-Q prediction function for counter_checker.
// The prediction works on a MAX_W-bit container; callers pass the real width.
package counter_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        CHECK = 2'd2
    } state_t;

    localparam int unsigned MAX_W = 32;

    typedef struct packed {
        logic cnt_reset;
        logic load;
        logic enable;
        logic updn;
    } ctrl_t;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned width);
        if (width >= MAX_W)
            return '1;
        return (MAX_W'(1) << width) - MAX_W'(1);
    endfunction

    // Priority: counter reset, then load (regardless of enable), then count.
    function automatic logic [MAX_W-1:0] predict(
        input logic [MAX_W-1:0] q,
        input logic [MAX_W-1:0] data,
        input ctrl_t            ctrl,
        input int unsigned      width
    );
        logic [MAX_W-1:0] nxt;
        if (ctrl.cnt_reset)
            nxt = '0;
        else if (ctrl.load)
            nxt = data;
        else if (ctrl.enable)
            nxt = ctrl.updn ? q + MAX_W'(1) : q - MAX_W'(1);
        else
            nxt = q;
        return nxt & width_mask(width);
    endfunction

    function automatic logic wraps(
        input logic [MAX_W-1:0] q,
        input ctrl_t            ctrl,
        input int unsigned      width
    );
        logic [MAX_W-1:0] qm;
        qm = q & width_mask(width);
        return ctrl.enable && !ctrl.load && !ctrl.cnt_reset &&
               ((ctrl.updn && qm == width_mask(width)) || (!ctrl.updn && qm == '0));
    endfunction

endpackage

// File: rtl/counter_checker_capture.sv
// Error bookkeeping for counter_checker: sticky flag, saturating count and
// first-mismatch capture; a synchronous clear overrides a same-edge mismatch.
module counter_checker_capture #(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             mismatch,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] got,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err       <= 1'b0;
            err_count <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else if (clear) begin
            err       <= 1'b0;
            err_count <= '0;
            first_exp <= '0;
            first_got <= '0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (err_count != '1)
                err_count <= err_count + ERR_W'(1);
            if (!err) begin
                first_exp <= exp;
                first_got <= got;
            end
        end
    end

endmodule

// File: rtl/counter_checker.sv
// Cycle-level checker for the up/down/load counter: predicts next Q, compares
// one clock later. Optional wrap pulse built when COUNTER_CHECKER_WRAP_EN is defined.
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cnt_reset,
    input  logic             enable,
    input  logic             load,
    input  logic             updn,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] q,
    input  logic             check_en,
    input  logic             clear,
    output logic             err,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_got,
    output logic             wrap
);

    state_t           state, state_next;
    logic [WIDTH-1:0] pred, pred_next, f_q;
    logic             mismatch;
    ctrl_t            ctrl;

    assign ctrl = {cnt_reset, load, enable, updn};
    assign f_q  = WIDTH'(predict(MAX_W'(q), MAX_W'(data), ctrl, WIDTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            pred  <= '0;
        end else begin
            state <= state_next;
            pred  <= pred_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        pred_next  = pred;
        mismatch   = 1'b0;
        case (state)
            IDLE: begin
                if (check_en)
                    state_next = PRIME;
            end
            PRIME: begin
                pred_next  = f_q;
                state_next = CHECK;
            end
            CHECK: begin
                // NOTE: case inequality so an X/Z on q reads as a mismatch in
                // simulation; hardware sees an ordinary compare.
                mismatch  = (q !== pred);
                pred_next = f_q;
            end
            default: state_next = IDLE;
        endcase
        if (!check_en)
            state_next = IDLE;
    end

    counter_checker_capture #(
        .WIDTH (WIDTH),
        .ERR_W (ERR_W)
    ) u_capture (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear),
        .mismatch  (mismatch),
        .exp       (pred),
        .got       (q),
        .err       (err),
        .err_count (err_count),
        .first_exp (first_exp),
        .first_got (first_got)
    );

`ifdef COUNTER_CHECKER_WRAP_EN
    // Registered on the edge that forms the prediction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            wrap <= 1'b0;
        else
            wrap <= (state != IDLE) && wraps(MAX_W'(q), ctrl, WIDTH);
    end
`else
    assign wrap = 1'b0;
`endif

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: the bench plays the counter (with fault injection)
// and checks the checker's flags against hand-derived vectors via a scoreboard.
module tb_counter_checker;

    localparam int WIDTH = 8;
    localparam int ERR_W = 4;
`ifdef COUNTER_CHECKER_WRAP_EN
    localparam logic WRAP_ON = 1'b1;
`else
    localparam logic WRAP_ON = 1'b0;
`endif

    logic             clock, reset_n;
    logic             cnt_reset, enable, load, updn, check_en, clear;
    logic [WIDTH-1:0] data, q;
    logic             err, wrap;
    logic [ERR_W-1:0] err_count;
    logic [WIDTH-1:0] first_exp, first_got;

    counter_checker #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .cnt_reset (cnt_reset),
        .enable    (enable),
        .load      (load),
        .updn      (updn),
        .data      (data),
        .q         (q),
        .check_en  (check_en),
        .clear     (clear),
        .err       (err),
        .err_count (err_count),
        .first_exp (first_exp),
        .first_got (first_got),
        .wrap      (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    typedef struct {
        logic       cr, ld, en, ud;
        logic [7:0] d;
        logic       clr, flt;
        logic [7:0] fq;
        logic       e_err;
        logic [3:0] e_cnt;
        logic       e_wrap;
        logic [7:0] e_fexp, e_fgot;
    } vec_t;

    typedef struct {
        string      tag;
        logic       err;
        logic [3:0] cnt;
        logic       wrap;
        logic [7:0] fexp, fgot;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic cr, ld, en, ud, input logic [7:0] d,
                                input logic clr, flt, input logic [7:0] fq,
                                input logic e_err, input logic [3:0] e_cnt, input logic e_wrap,
                                input logic [7:0] e_fexp, e_fgot);
        vec_t v;
        v.cr = cr; v.ld = ld; v.en = en; v.ud = ud; v.d = d;
        v.clr = clr; v.flt = flt; v.fq = fq;
        v.e_err = e_err; v.e_cnt = e_cnt; v.e_wrap = e_wrap;
        v.e_fexp = e_fexp; v.e_fgot = e_fgot;
        return v;
    endfunction

    // Acts as the counter: controls set now, Q updates just after the edge.
    task automatic drive(input logic cr, ld, en, ud, input logic [7:0] d,
                         input logic clr, flt, input logic [7:0] fq);
        logic [7:0] nxt;
        cnt_reset = cr; load = ld; enable = en; updn = ud; data = d; clear = clr;
        if (cr)       nxt = 8'h00;
        else if (ld)  nxt = d;
        else if (en)  nxt = ud ? q + 8'd1 : q - 8'd1;
        else          nxt = q;
        if (flt) nxt = fq;
        @(posedge clock);
        #1;
        q = nxt;
    endtask

    task automatic compare_pop();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, " err"},       32'(err),       32'(e.err));
        check({e.tag, " err_count"}, 32'(err_count), 32'(e.cnt));
        check({e.tag, " wrap"},      32'(wrap),      32'(e.wrap));
        check({e.tag, " first_exp"}, 32'(first_exp), 32'(e.fexp));
        check({e.tag, " first_got"}, 32'(first_got), 32'(e.fgot));
    endtask

    task automatic push(input string tag, input logic e_err, input logic [3:0] e_cnt,
                        input logic e_wrap, input logic [7:0] e_fexp, e_fgot);
        exp_t e;
        e.tag = tag; e.err = e_err; e.cnt = e_cnt; e.wrap = e_wrap;
        e.fexp = e_fexp; e.fgot = e_fgot;
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        {cnt_reset, enable, load, updn, check_en, clear} = '0;
        data = '0;
        q    = '0;
        #12;
        push("reset", 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
        compare_pop();
        reset_n = 1'b1;

        //           cr ld en ud d      clr flt fq     err cnt  wrap     fexp   fgot
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=0
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=0
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=1
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=2
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=1
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=0
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, WRAP_ON, 8'h00, 8'h00)); // Q=255
        vecs.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=254
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00));
        vecs.push_back(mk(0, 1, 0, 0, 8'h02, 0, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // Q=2
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 1, 8'h05, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // bad: 5 for 3
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 8'h00, 1, 4'd1, 1'b0,    8'h03, 8'h05)); // error seen
        vecs.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 8'h00, 1, 4'd1, 1'b0,    8'h03, 8'h05)); // no new error
        vecs.push_back(mk(0, 1, 0, 0, 8'h10, 1, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // clear, Q=10
        vecs.push_back(mk(0, 1, 1, 1, 8'hA5, 0, 1, 8'h11, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // load+en, bad 11
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 1, 8'h40, 1, 4'd1, 1'b0,    8'hA5, 8'h11)); // error, bad 40
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'd0, 1'b0,    8'h00, 8'h00)); // clear beats mismatch

        check_en = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            push($sformatf("vec%0d", i), vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_wrap,
                 vecs[i].e_fexp, vecs[i].e_fgot);
            drive(vecs[i].cr, vecs[i].ld, vecs[i].en, vecs[i].ud, vecs[i].d,
                  vecs[i].clr, vecs[i].flt, vecs[i].fq);
            compare_pop();
        end

        // Every step faulty: count saturates at 2^ERR_W-1.
        for (int i = 0; i < 20; i++) begin
            int exp_cnt;
            exp_cnt = (i > 15) ? 15 : i;
            push($sformatf("sat%0d", i), i >= 1, 4'(exp_cnt), 1'b0,
                 (i >= 1) ? 8'h40 : 8'h00, (i >= 1) ? 8'h50 : 8'h00);
            drive(0, 0, 0, 0, 8'h00, 0, 1, 8'h50 + 8'(i));
            compare_pop();
        end

        // Mid-cycle reset with a mismatch pending on q.
        #3;
        reset_n = 1'b0;
        #1;
        push("async_reset", 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
        compare_pop();
        q = 8'h77;
        #2;
        reset_n = 1'b1;

        push("rearm_edge1", 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        compare_pop();
        push("rearm_edge2", 1'b0, 4'd0, 1'b0, 8'h00, 8'h00);
        drive(0, 0, 0, 0, 8'h00, 0, 1, 8'h78);
        compare_pop();
        push("rearm_edge3", 1'b1, 4'd1, 1'b0, 8'h77, 8'h78);
        drive(0, 0, 0, 0, 8'h00, 0, 0, 8'h00);
        compare_pop();

        // Disarm: a fault after Check_en drops must not count.
        check_en = 1'b0;
        push("disarm_edge1", 1'b1, 4'd1, 1'b0, 8'h77, 8'h78);
        drive(0, 0, 0, 0, 8'h00, 0, 1, 8'h90);
        compare_pop();
        push("disarm_edge2", 1'b1, 4'd1, 1'b0, 8'h77, 8'h78);
        drive(0, 0, 0, 0, 8'h00, 0, 1, 8'h91);
        compare_pop();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/counter_checker.md
# counter_checker

- Cycle-level hardware checker on the output side of the 8-bit up/down/load counter.
- Observes the same control inputs as the counter and predicts each next Q from the current Q.
- Compares that prediction against the counter's actual Q one clock later.
- Reports a sticky error, a saturating error count and the first failing pair; replaces the per-time-slot OK-flag checks in benches and can stay in silicon as a self-test monitor.

## Interface
- WIDTH, 8, counter data width
- ERR_W, 16, error-counter width
- Clock  in  1  rising-edge clock, shared with the counter
- Reset_n  in  1  asynchronous active-low reset of the checker itself
- Cnt_reset  in  1  counter's synchronous active-high reset, observed
- Enable  in  1  counter count enable, observed
- Load  in  1  counter parallel load, observed
- UpDn  in  1  1 = count up, 0 = count down, observed
- Data  in  WIDTH  counter load value, observed
- Q  in  WIDTH  counter output under check
- Check_en  in  1  arms checking; 0 = idle
- Clear  in  1  synchronous clear of Err, Err_count and the captured pair
- Err  out  1  sticky mismatch flag
- Err_count  out  ERR_W  number of mismatching cycles, saturating
- First_exp  out  WIDTH  predicted value at the first mismatch
- First_got  out  WIDTH  actual Q at the first mismatch
- Wrap  out  1  one-cycle pulse on a predicted wrap (present only with the macro)

## Operation
- Prediction function f(Q, controls), with priority Cnt_reset > Load > Enable:
  - Cnt_reset: 0
  - else Load: Data, independent of Enable
  - else Enable and UpDn: Q+1 mod 2^WIDTH
  - else Enable and not UpDn: Q-1 mod 2^WIDTH
  - else: Q
- FSM states are IDLE, PRIME and CHECK.
  - IDLE: no compares. Check_en=1 moves to PRIME.
  - PRIME: Pred <= f(Q, controls). No compare. Moves to CHECK.
  - CHECK: each edge compares Q with Pred, then Pred <= f(Q, controls).
  - Check_en=0 in any state returns to IDLE at the next edge. The compare on that edge is still performed when the state is CHECK.
- A mismatch in CHECK has these effects:
  - Err <= 1.
  - Err_count increments, saturating at 2^ERR_W-1.
  - If Err was 0, First_exp <= Pred and First_got <= Q.
- Clear has priority over a mismatch on the same edge. Err, Err_count, First_exp and First_got all go to 0, and the mismatch is discarded.
- Prediction always resynchronises to the actual Q, so one bad step produces exactly one error.
- Any X or Z on Q during a compare counts as a mismatch.

## Timing
- Reset_n low asynchronously sets:
  - state to IDLE
  - Pred, Err, Err_count, First_exp and First_got to 0
  - Wrap to 0
- Counter update edge k consumes controls(k) and produces Q_k. The checker forms Pred from Q_{k-1} and controls(k) on the same edge k.
- The compare happens at edge k+1. Err is visible one cycle after the faulty counter edge.
- After Check_en rises (sampled at edge n), the first compare occurs at edge n+2.
- Simultaneous Load and Enable: the load wins. Load=1 with Enable=0 still loads.
- Wrap-around is modular: 255 up to 0 and 0 down to 255 are correct, not errors.
- Reset_n asserted mid-operation aborts checking immediately. Checking needs Check_en and a fresh PRIME after release.

## Configuration
- COUNTER_CHECKER_WRAP_EN defined:
  - Wrap pulses for one cycle whenever the predicted value wraps, i.e. Enable=1 and Load=0 and Cnt_reset=0, with UpDn=1 and Q=all-ones, or UpDn=0 and Q=0.
  - The pulse is registered and asserted after the predicting edge.
- Undefined: the Wrap port still exists and is tied to 0. No wrap logic is built.

## Structure
- Package counter_checker_pkg holds:
  - the state enum (IDLE, PRIME, CHECK)
  - the prediction function f, parameterised by WIDTH and reused by bench models
- One sub-module, counter_checker_capture, holds the error counter, the sticky flag and the first-pair capture with the Clear/mismatch priority.

## Test plan
- Replay the standard sequence (counter reset 1 cycle, idle 1 cycle, count up 2, count down 4) with Check_en=1: Err=0, Err_count=0, Q trace 0,0,1,2,1,0,255,254.
- Down-count through 0 with COUNTER_CHECKER_WRAP_EN: exactly one Wrap pulse on the 0 to 255 step, Err=0.
- Inject a fault, forcing Q=5 where 3 is predicted: Err rises one cycle later, Err_count=1, First_exp=3, First_got=5. The next correct step adds no error.
- Load=1, Enable=1, Data=8'hA5 at Q=8'h10: predicted A5. A counter that instead increments to 11 gives an error with First_exp=A5.
- Assert Clear on the same edge as a mismatch: counter and flags are all 0. Drive continuous mismatches with ERR_W=4: Err_count saturates at 15.
- Assert Reset_n mid-CHECK with a pending mismatch: outputs clear asynchronously. Then raise Check_en: no compare before the second edge.
